// File: rtl/bcd_multi_code_counter.sv
// Cascaded decade up/down counter with synchronous load. Each digit is kept as a binary
// value 0..9 and is encoded to 8421, 2421 (Aiken) or excess-3 on the output side only.
module bcd_multi_code_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [1:0]            mode,
    output logic [4*DIGITS-1:0]   out_code,
    output logic                  tc,
    output logic                  wrap
);

    logic [4*DIGITS-1:0] w_digits;
    logic [DIGITS:0]     w_carry;
    logic [DIGITS:0]     w_borrow;
    logic                r_wrap;

    function automatic logic [3:0] f_encode(input logic [3:0] d, input logic [1:0] m);
        logic [3:0] e;
        e = d;
        case (m)
            2'b01:   e = (d > 4'd4) ? d + 4'd6 : d;
            2'b10:   e = d + 4'd3;
            default: e = d;
        endcase
        return e;
    endfunction

    // Any out-of-range value is steered back into 0..9 so the digit can never stick there.
    function automatic logic [3:0] f_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] f_dec(input logic [3:0] d);
        return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
    endfunction

    function automatic logic [3:0] f_sanitize(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

    // w_carry[k] / w_borrow[k]: every digit below k sits at 9 / at 0.
    always_comb begin
        w_carry  = '0;
        w_borrow = '0;
        w_carry[0]  = 1'b1;
        w_borrow[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            w_carry[k+1]  = w_carry[k]  & (w_digits[4*k +: 4] == 4'd9);
            w_borrow[k+1] = w_borrow[k] & (w_digits[4*k +: 4] == 4'd0);
        end
    end

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            logic [3:0] r_val;
            logic [3:0] w_nib;
            logic       w_step;

            assign w_nib  = load_val[4*g +: 4];
            assign w_step = up ? w_carry[g] : w_borrow[g];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_val <= 4'd0;
                end else if (load) begin
                    r_val <= f_sanitize(w_nib);
                end else if (en && w_step) begin
                    r_val <= up ? f_inc(r_val) : f_dec(r_val);
                end
            end

            assign w_digits[4*g +: 4] = r_val;
            assign out_code[4*g +: 4] = f_encode(r_val, mode);
        end
    endgenerate

    assign tc = en & ~load & (up ? w_carry[DIGITS] : w_borrow[DIGITS]);

    // tc is already zero on load and hold cycles, so registering it gives the wrap pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= tc;
        end
    end

    assign wrap = r_wrap;

endmodule

// File: tb/tb_bcd_multi_code_counter.sv
// Directed bench for bcd_multi_code_counter: a 2-digit and a 3-digit instance share clock and reset.
module tb_bcd_multi_code_counter;

  logic        clk;
  logic        rst;

  logic        en;
  logic        up;
  logic        load;
  logic [7:0]  load_val;
  logic [1:0]  mode;
  logic [7:0]  out_code;
  logic        tc;
  logic        wrap;

  logic        d3_en;
  logic        d3_up;
  logic        d3_load;
  logic [11:0] d3_load_val;
  logic [1:0]  d3_mode;
  logic [11:0] d3_out_code;
  logic        d3_tc;
  logic        d3_wrap;

  int n_cmp;
  int n_err;

  logic [3:0] aiken [10];
  logic [7:0] exp_bcd;

  bcd_multi_code_counter #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .mode(mode), .out_code(out_code), .tc(tc), .wrap(wrap)
  );

  bcd_multi_code_counter #(.DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .en(d3_en), .up(d3_up), .load(d3_load), .load_val(d3_load_val),
    .mode(d3_mode), .out_code(d3_out_code), .tc(d3_tc), .wrap(d3_wrap)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, required finish");
    $fatal(1, "watchdog expired");
  end

  // driver helpers
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    aiken = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    rst = 1'b0;
    en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00; mode = 2'b00;
    d3_en = 1'b0; d3_up = 1'b1; d3_load = 1'b0; d3_load_val = 12'h000; d3_mode = 2'b00;

    // reset state
    #12;
    chk("reset_out", {24'h0, out_code}, 32'h00);
    chk("reset_wrap", {31'h0, wrap}, 32'h0);
    chk("reset_tc", {31'h0, tc}, 32'h0);
    chk("reset_d3_out", {20'h0, d3_out_code}, 32'h000);
    @(negedge clk);
    rst = 1'b1;

    // full up-count 00..99 -> 00
    en = 1'b1; up = 1'b1;
    #1;
    chk("up_tc_at_0", {31'h0, tc}, 32'h0);
    for (int i = 1; i <= 100; i++) begin
      tick();
      exp_bcd = {4'((i % 100) / 10), 4'((i % 100) % 10)};
      chk("up_out", {24'h0, out_code}, {24'h0, exp_bcd});
      chk("up_wrap", {31'h0, wrap}, {31'h0, (i == 100)});
      chk("up_tc", {31'h0, tc}, {31'h0, (i == 99)});
    end

    // 2421 sequence on digit 0
    en = 1'b0; mode = 2'b01; load = 1'b1; load_val = 8'h00;
    tick();
    load = 1'b0;
    chk("aiken_0", {24'h0, out_code}, 32'h00);
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("aiken_seq", {24'h0, out_code}, {24'h0, 4'h0, aiken[i]});
    end
    en = 1'b0;

    // mode switch at 47 never alters the count
    load = 1'b1; load_val = 8'h47; mode = 2'b00;
    tick();
    load = 1'b0;
    chk("m00_47", {24'h0, out_code}, 32'h47);
    mode = 2'b10; #1;
    chk("m10_47", {24'h0, out_code}, 32'h7A);
    mode = 2'b01; #1;
    chk("m01_47", {24'h0, out_code}, 32'h4D);
    mode = 2'b11; #1;
    chk("m11_47", {24'h0, out_code}, 32'h47);
    tick();
    mode = 2'b00; #1;
    chk("m00_47_hold", {24'h0, out_code}, 32'h47);
    chk("hold_wrap", {31'h0, wrap}, 32'h0);

    // load sanitising and load-over-en priority
    @(negedge clk);
    load = 1'b1; load_val = 8'h3C;
    tick();
    chk("load_3C", {24'h0, out_code}, 32'h30);
    load_val = 8'hFF;
    tick();
    chk("load_FF", {24'h0, out_code}, 32'h00);
    load_val = 8'h9A;
    tick();
    chk("load_9A", {24'h0, out_code}, 32'h90);
    load_val = 8'h99;
    tick();
    chk("load_99", {24'h0, out_code}, 32'h99);
    en = 1'b1; up = 1'b1; load_val = 8'h25; #1;
    chk("load_en_tc", {31'h0, tc}, 32'h0);
    tick();
    chk("load_en_out", {24'h0, out_code}, 32'h25);
    chk("load_en_wrap", {31'h0, wrap}, 32'h0);

    // down count through 00 -> 99
    en = 1'b0; load_val = 8'h01;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0; #1;
    chk("dn_tc_01", {31'h0, tc}, 32'h0);
    tick();
    chk("dn_out_00", {24'h0, out_code}, 32'h00);
    chk("dn_tc_00", {31'h0, tc}, 32'h1);
    tick();
    chk("dn_out_99", {24'h0, out_code}, 32'h99);
    chk("dn_wrap_99", {31'h0, wrap}, 32'h1);
    chk("dn_tc_99", {31'h0, tc}, 32'h0);
    tick();
    chk("dn_out_98", {24'h0, out_code}, 32'h98);
    chk("dn_wrap_98", {31'h0, wrap}, 32'h0);

    // direction change
    up = 1'b1;
    tick();
    chk("dir_up_99", {24'h0, out_code}, 32'h99);
    chk("dir_tc_99", {31'h0, tc}, 32'h1);
    up = 1'b0;
    tick();
    chk("dir_dn_98", {24'h0, out_code}, 32'h98);

    // asynchronous reset at 57
    en = 1'b0; load = 1'b1; load_val = 8'h57;
    tick();
    load = 1'b0;
    chk("pre_rst_57", {24'h0, out_code}, 32'h57);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out", {24'h0, out_code}, 32'h00);
    mode = 2'b10; #1;
    chk("async_rst_xs3", {24'h0, out_code}, 32'h33);
    chk("async_rst_d3", {20'h0, d3_out_code}, 32'h000);
    mode = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out", {24'h0, out_code}, 32'h00);
      chk("hold_wrap0", {31'h0, wrap}, 32'h0);
    end

    // three-digit cascade
    d3_load = 1'b1; d3_load_val = 12'h998;
    tick();
    d3_load = 1'b0; d3_en = 1'b1; d3_up = 1'b1; #1;
    chk("d3_998", {20'h0, d3_out_code}, 32'h998);
    chk("d3_tc_998", {31'h0, d3_tc}, 32'h0);
    tick();
    chk("d3_999", {20'h0, d3_out_code}, 32'h999);
    chk("d3_tc_999", {31'h0, d3_tc}, 32'h1);
    tick();
    chk("d3_000", {20'h0, d3_out_code}, 32'h000);
    chk("d3_wrap_000", {31'h0, d3_wrap}, 32'h1);
    d3_mode = 2'b10; #1;
    chk("d3_xs3_000", {20'h0, d3_out_code}, 32'h333);
    d3_mode = 2'b00;
    tick();
    chk("d3_001", {20'h0, d3_out_code}, 32'h001);
    chk("d3_wrap_001", {31'h0, d3_wrap}, 32'h0);
    d3_en = 1'b0; d3_load = 1'b1; d3_load_val = 12'h100;
    tick();
    d3_load = 1'b0; d3_en = 1'b1; d3_up = 1'b0;
    chk("d3_100", {20'h0, d3_out_code}, 32'h100);
    tick();
    chk("d3_099", {20'h0, d3_out_code}, 32'h099);
    chk("d3_tc_099", {31'h0, d3_tc}, 32'h0);
    tick();
    chk("d3_098", {20'h0, d3_out_code}, 32'h098);
    d3_en = 1'b0;

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_multi_code_counter.md
Name: bcd_multi_code_counter

Overview:
- Parametrised successor to the single-digit 4-bit 2421 counter.
- Cascades DIGITS decade stages and supports up/down counting, synchronous load and enable.
- Output code is run-time selectable: 8421 BCD, 2421 (Aiken) or excess-3.
- Drives display/decoder logic and chains to further counters via terminal-count and wrap outputs.

Parameters:
- DIGITS, 2, number of cascaded decade digits (1..8); total count range 0 .. 10^DIGITS-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  4*DIGITS  load value, 8421 BCD per digit, digit 0 in [3:0].
- mode  input  2  output code: 00 = 8421, 01 = 2421, 10 = excess-3, 11 = 8421.
- out_code  output  4*DIGITS  per-digit encoded count, digit 0 in [3:0].
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse on wrap-around.

Behaviour:
- State: one 4-bit binary digit register per digit, each holding 0..9, plus the wrap register.
- Reset (rst low, asynchronous): all digits = 0; wrap = 0.
  - out_code then reads 0 in modes 00/01/11 and 0x3 per digit in mode 10.
  - Reset mid-count takes effect immediately, independent of clk.
- Priority each rising edge: load > en > hold.
- Load:
  - Each digit takes its load_val nibble.
  - Any nibble > 9 loads 0 for that digit only.
  - wrap = 0 in the load cycle.
- Count up (en=1, up=1):
  - Digit 0 increments.
  - Digit k increments only when digits 0..k-1 are all 9.
  - A digit at 9 that steps goes to 0.
- Count down (en=1, up=0):
  - Digit 0 decrements.
  - Digit k decrements only when digits 0..k-1 are all 0.
  - A digit at 0 that steps goes to 9.
- Wrap-around:
  - All-9s up → all-0s.
  - All-0s down → all-9s.
  - wrap = 1 for exactly the cycle after such a step; otherwise 0.
- Hold (en=0, load=0): digits unchanged; wrap = 0.
- tc = en & ~load & (up ? all digits == 9 : all digits == 0). It is combinational, so it can gate the next stage's en with zero latency.
- Latency: one clock from en/load to the new out_code.
- mode is combinational onto out_code; a mode change is visible the same cycle and never alters the count.
- Encoding per digit value d:
  - 8421: d.
  - 2421: 0-4 → 0000, 0001, 0010, 0011, 0100; 5-9 → 1011, 1100, 1101, 1110, 1111.
  - excess-3: d+3 (0011..1100).
- Direction change mid-count: takes effect on the next enabled edge, with no extra step.
- Simultaneous load and en: load wins; no count step; tc = 0.
- Invariant: digit registers never hold 10..15. An implementation that can reach them is non-compliant.

Test Plan:
- DIGITS=2, mode=00, rst low 10 ns then high, en=1, up=1 for 100 cycles → out_code steps 0x00..0x99, then 0x00. wrap=1 exactly one cycle after the 99→00 edge. tc=1 only while the count is 99.
- mode=01, count up from 0 → digit 0 sequence 0000, 0001, 0010, 0011, 0100, 1011, 1100, 1101, 1110, 1111. Switching to mode=10 at count 47 → out_code=0x7A with the count unchanged.
- load=1, load_val=0x3C → count 30, so mode 00 out_code=0x30. Next, load=1 and en=1 with load_val=0x25 → count 25, no step, tc=0.
- en=1, up=0 from a loaded 0x01 → 0x00 (tc=1), then 0x99 with wrap=1 for one cycle, then 0x98.
- Assert rst low asynchronously between clock edges at count 57 → out_code=0x00 immediately (0x33 in mode 10). Release rst, then en=0 for 5 cycles → count holds 0 and wrap stays 0.
- DIGITS=3, up count from a loaded 0x998 → 999 (tc=1), then 000 with wrap pulse. Down from 100 → 099, checking the cascaded borrow.
